// File: rtl/wb_buffer.sv
// Write-back buffer: a small in-order FIFO of pending register-file writes.
// It drains through a shared write port and forwards pending data to two read ports.
module wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_Wn,
  input  logic [31:0]              in_Wd,
  input  logic                     port_busy,
  output logic                     Write,
  output logic [4:0]               Wn,
  output logic [31:0]              Wd,
  input  logic [4:0]               Rn1,
  input  logic [4:0]               Rn2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [31:0]              fwd1,
  output logic [31:0]              fwd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    wn_mem [DEPTH];
  logic [31:0]   wd_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          push;
  logic          pop;
  logic          not_empty;

  assign not_empty = (count != '0);
  assign in_ready  = (count < CW'(DEPTH));
  // Register 0 is never written, so such requests complete the handshake and vanish.
  assign push      = in_valid && in_ready && (in_Wn != 5'd0);
  assign Write     = not_empty && !port_busy;
  assign pop       = Write;
  assign Wn        = not_empty ? wn_mem[head] : 5'd0;
  assign Wd        = not_empty ? wd_mem[head] : 32'd0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry storage has no reset; every read of it is qualified by
  // count, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      wn_mem[tail] <= in_Wn;
      wd_mem[tail] <= in_Wd;
    end
  end

  // Scans oldest to youngest so the last match (the youngest) wins.
  function automatic logic [32:0] lookup(input logic [4:0] rn);
    logic [AW-1:0] idx;
    logic [32:0]   res;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((CW'(i) < count) && (rn != 5'd0) && (wn_mem[idx] == rn))
        res = {1'b1, wd_mem[idx]};
    end
    return res;
  endfunction

  // NOTE: every output of this block is assigned before any condition, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    {hit1, fwd1} = '0;
    {hit2, fwd2} = '0;
    {hit1, fwd1} = lookup(Rn1);
    {hit2, fwd2} = lookup(Rn2);
  end

endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of pending write-back entries (power of two, 2..16).
REQ-002 The block SHALL have clk  input  1  system clock, all state updates on the rising edge.
REQ-003 The block SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have in_valid  input  1  producer presents a write-back request.
REQ-005 The block SHALL have in_ready  output  1  buffer can accept a request this cycle.
REQ-006 The block SHALL have in_Wn  input  5  destination register number of the request.
REQ-007 The block SHALL have in_Wd  input  32  data of the request.
REQ-008 The block SHALL have port_busy  input  1  register-file write port is taken by another master this cycle.
REQ-009 The block SHALL have Write  output  1  register-file write enable.
REQ-010 The block SHALL have Wn  output  5  register-file write address.
REQ-011 The block SHALL have Wd  output  32  register-file write data.
REQ-012 The block SHALL have Rn1, Rn2  input  5 each  read-port addresses being looked up.
REQ-013 The block SHALL have hit1, hit2  output  1 each  a pending entry targets Rn1 / Rn2.
REQ-014 The block SHALL have fwd1, fwd2  output  32 each  forwarded data for Rn1 / Rn2.
REQ-015 The block SHALL have count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 The block SHALL store entries in a circular FIFO (head pointer, tail pointer, count) in arrival order.
REQ-017 in_ready SHALL be 1 exactly when count < DEPTH; a push SHALL occur on a rising edge with in_valid && in_ready.
REQ-018 A request with in_Wn == 0 SHALL be accepted (handshake completes) but not stored; count unchanged by it.
REQ-019 Write SHALL equal (count != 0) && !port_busy, combinationally; Wn/Wd SHALL show the head entry whenever count != 0, else 0.
REQ-020 A pop SHALL occur on each rising edge where Write == 1; head advances by one, wrapping DEPTH-1 -> 0.
REQ-021 Latency: a request accepted at edge t SHALL appear on Write no earlier than the cycle after t (no same-cycle bypass to the write port).
REQ-022 Simultaneous push and pop SHALL both take effect; count unchanged; when full, in_ready stays 0 that cycle even if a pop occurs.
REQ-023 port_busy SHALL only stall draining; the head entry and its order SHALL be held unchanged while stalled.
REQ-024 hitN SHALL be 1 when RnN != 0 and any valid entry has Wn == RnN; fwdN SHALL be the Wd of the youngest matching entry.
REQ-025 When no entry matches, or RnN == 0, hitN SHALL be 0 and fwdN SHALL be 0.
REQ-026 Lookup SHALL include the head entry in the cycle it is being written; entries pushed on the current edge are visible only from the next cycle.
REQ-027 Duplicate destinations SHALL each be kept and written in order, so the register file ends with the youngest value.
REQ-028 Pointer and count arithmetic SHALL wrap modulo DEPTH / saturate never; count SHALL never exceed DEPTH nor go below 0.

Reset
REQ-029 While rst_n == 0, count, head and tail SHALL be 0, and Write, hit1, hit2 SHALL be 0 asynchronously.
REQ-030 Reset asserted with entries pending SHALL discard them; no Write pulse SHALL be issued for them after release.
REQ-031 After rst_n rises, in_ready SHALL be 1 in the first cycle; entry data storage need not be reset.

Verification
REQ-032 Push {Wn=5,Wd=0x11} with port_busy=0 -> next cycle Write=1, Wn=5, Wd=0x11; following cycle Write=0, count=0.
REQ-033 port_busy=1, push 4 entries Wn=1..4 -> count=4, in_ready=0, 5th request not accepted; release port_busy -> Write=1 for 4 consecutive cycles, Wn=1,2,3,4.
REQ-034 Push Wn=7 Wd=0xA then Wn=7 Wd=0xB (busy=1), Rn1=7, Rn2=0 -> hit1=1, fwd1=0xB, hit2=0, fwd2=0; after drain register 7 holds 0xB.
REQ-035 Full buffer, port_busy=0, in_valid=1 -> one pop per cycle, push accepted from the cycle count drops to 3; pointers wrap with order preserved across 10 pushes.
REQ-036 Push in_Wn=0 -> in_ready=1, count stays 0, Write never asserted.
REQ-037 3 entries pending, assert rst_n=0 mid-cycle -> Write=0 immediately, count=0; after release no write-back for discarded entries.
